display_source_mux: RTL and testbench

Parametrised N-channel, registered source selector for the clock's display path. It chooses one of `CHANNELS` packed `WIDTH`-bit digit groups, such as time, date, alarm or set-mode, and drives the chosen group to the display driver. It supports two modes: manual selection, and an auto-rotate mode that dwells on each enabled channel for a fixed number of cycles. It emits a strobe whenever the displayed source changes.

---
 rtl/display_source_mux.sv | 72 +++++++
 tb/tb_display_source_mux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/display_source_mux.sv
// Registered N-channel source selector for the display path.
// Manual channel pick or auto-rotation over enabled channels, with a change strobe.
module display_source_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int DWELL    = 100_000_000,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_manual,
   input  logic [CHANNELS-1:0]       chan_enable,
   input  logic [CHANNELS*WIDTH-1:0] group_in,
   output logic [WIDTH-1:0]          group_out,
   output logic [SEL_W-1:0]          active_sel,
   output logic                      switch_strobe
);

   localparam int               CNT_W    = $clog2(DWELL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt, cnt_next;
   logic [SEL_W-1:0] sel_next, rot_next;
   logic             rot_found, cur_en;

   // Nearest enabled channel after the current one; descending loop lets the smallest offset win.
   always_comb begin
      rot_found = 1'b0;
      rot_next  = active_sel;
      cur_en    = 1'b0;
      for (int k = CHANNELS - 1; k >= 1; k--) begin
         if (chan_enable[(int'(active_sel) + k) % CHANNELS]) begin
            rot_found = 1'b1;
            rot_next  = SEL_W'((int'(active_sel) + k) % CHANNELS);
         end
      end
      for (int i = 0; i < CHANNELS; i++) begin
         if (SEL_W'(i) == active_sel) cur_en = chan_enable[i];
      end
   end

   always_comb begin
      sel_next = active_sel;
      cnt_next = '0;
      if (!mode) begin
         if (int'(sel_manual) < CHANNELS) sel_next = sel_manual;
      end else if (!cur_en && rot_found) begin
         sel_next = rot_next;
      end else if (cnt == CNT_LAST) begin
         // With nothing else enabled the counter still wraps, just without a switch.
         if (rot_found) sel_next = rot_next;
      end else begin
         cnt_next = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         active_sel    <= '0;
         group_out     <= '0;
         switch_strobe <= 1'b0;
      end else begin
         cnt           <= cnt_next;
         active_sel    <= sel_next;
         group_out     <= group_in[int'(sel_next)*WIDTH +: WIDTH];
         switch_strobe <= (sel_next != active_sel);
      end
   end

endmodule

// File: tb/tb_display_source_mux.sv
// Bench for display_source_mux: directed scenarios plus random traffic,
// all checked against a queue-based behavioural model of the selection rules.
module tb_display_source_mux;
   localparam int W = 16, C = 4, D = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           mode;
   logic [1:0]     sel_manual;
   logic [C-1:0]   chan_enable;
   logic [C*W-1:0] group_in;
   logic [W-1:0]   group_out;
   logic [1:0]     active_sel;
   logic           switch_strobe;

   logic [1:0]     sel_manual3;
   logic [2:0]     chan_enable3;
   logic [3*W-1:0] group_in3;
   logic [W-1:0]   group_out3;
   logic [1:0]     active_sel3;
   logic           switch_strobe3;
   logic           mode3;

   always #5 clk = ~clk;

   display_source_mux #(.WIDTH(W), .CHANNELS(C), .DWELL(D)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel_manual(sel_manual),
      .chan_enable(chan_enable), .group_in(group_in), .group_out(group_out),
      .active_sel(active_sel), .switch_strobe(switch_strobe));

   display_source_mux #(.WIDTH(W), .CHANNELS(3), .DWELL(D)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel_manual(sel_manual3),
      .chan_enable(chan_enable3), .group_in(group_in3), .group_out(group_out3),
      .active_sel(active_sel3), .switch_strobe(switch_strobe3));

   int n_chk = 0, n_fail = 0;
   int m_sel = 0, m_cnt = 0;
   int e_sel;
   bit e_stb;
   logic [W-1:0] e_grp;
   logic [W-1:0] gtab [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

   // Model: candidates are the enabled channels in rotation order after the current one.
   task automatic model_step();
      int cand[$];
      int nsel, ncnt;
      for (int k = 1; k < C; k++)
         if (chan_enable[(m_sel + k) % C]) cand.push_back((m_sel + k) % C);
      if (!mode) begin
         ncnt = 0;
         nsel = (int'(sel_manual) < C) ? int'(sel_manual) : m_sel;
      end else if (!chan_enable[m_sel] && cand.size() > 0) begin
         nsel = cand[0];
         ncnt = 0;
      end else begin
         ncnt = (m_cnt + 1) % D;
         nsel = (m_cnt == D - 1 && cand.size() > 0) ? cand[0] : m_sel;
      end
      e_stb = (nsel != m_sel);
      e_sel = nsel;
      e_grp = group_in[nsel*W +: W];
      m_sel = nsel;
      m_cnt = ncnt;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      mode = 0; sel_manual = 2; tick();
      rst_n = 0;
      #1;
      n_chk++; if (group_out !== 16'h0) begin n_fail++; $display("FAIL reset_group got %h want 0000", group_out); end
      n_chk++; if (active_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", active_sel); end
      n_chk++; if (switch_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b want 0", switch_strobe); end
      m_sel = 0; m_cnt = 0;
      rst_n = 1; mode = 0; sel_manual = 0;
      tick();
      n_chk++; if (group_out !== 16'hAAAA) begin n_fail++; $display("FAIL reset_first got %h want aaaa", group_out); end
      n_chk++; if (switch_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_first_stb got %b want 0", switch_strobe); end
   endtask

   task automatic test_manual();
      sel_manual = 2; tick();
      n_chk++; if (active_sel !== 2'd2 || group_out !== 16'hCCCC || switch_strobe !== 1'b1) begin
         n_fail++; $display("FAIL manual_sel got %0d/%h/%b want 2/cccc/1", active_sel, group_out, switch_strobe); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (switch_strobe !== 1'b0 || active_sel !== 2'd2) begin
            n_fail++; $display("FAIL manual_hold got %0d/%b want 2/0", active_sel, switch_strobe); end
      end
   endtask

   task automatic test_out_of_range();
      sel_manual3 = 1; tick(); tick();
      n_chk++; if (active_sel3 !== 2'd1 || group_out3 !== 16'hBBBB) begin
         n_fail++; $display("FAIL oor_setup got %0d/%h want 1/bbbb", active_sel3, group_out3); end
      sel_manual3 = 3;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (active_sel3 !== 2'd1 || switch_strobe3 !== 1'b0) begin
            n_fail++; $display("FAIL oor_hold got %0d/%b want 1/0", active_sel3, switch_strobe3); end
      end
   endtask

   task automatic test_auto_rotate();
      int st[$];
      int sa[$];
      mode = 0; sel_manual = 0; chan_enable = 4'hF; tick();
      mode = 1;
      for (int t = 1; t <= 25; t++) begin
         tick();
         n_chk++; if (active_sel !== 2'(e_sel) || switch_strobe !== e_stb) begin
            n_fail++; $display("FAIL auto_model got %0d/%b want %0d/%b", active_sel, switch_strobe, e_sel, e_stb); end
         if (switch_strobe) begin
            st.push_back(t); sa.push_back(int'(active_sel));
            n_chk++; if (group_out !== gtab[active_sel]) begin
               n_fail++; $display("FAIL auto_group got %h want %h", group_out, gtab[active_sel]); end
         end
      end
      n_chk++; if (st.size() != 5) begin n_fail++; $display("FAIL auto_count got %0d want 5", st.size()); end
      for (int j = 0; j < st.size() && j < 5; j++) begin
         n_chk++; if (st[j] != 5*(j+1) || sa[j] != (j+1) % 4) begin
            n_fail++; $display("FAIL auto_seq got t%0d/ch%0d want t%0d/ch%0d", st[j], sa[j], 5*(j+1), (j+1)%4); end
      end
   endtask

   task automatic test_masking();
      mode = 0; sel_manual = 1; tick();
      mode = 1; chan_enable = 4'b0101; tick();
      n_chk++; if (active_sel !== 2'd2 || switch_strobe !== 1'b1) begin
         n_fail++; $display("FAIL mask_skip got %0d/%b want 2/1", active_sel, switch_strobe); end
      for (int j = 0; j < 2; j++) begin
         for (int i = 0; i < 4; i++) tick();
         n_chk++; if (switch_strobe !== 1'b0) begin n_fail++; $display("FAIL mask_early got %b want 0", switch_strobe); end
         tick();
         n_chk++; if (switch_strobe !== 1'b1 || active_sel !== (j == 0 ? 2'd0 : 2'd2)) begin
            n_fail++; $display("FAIL mask_rot got %0d/%b want %0d/1", active_sel, switch_strobe, j == 0 ? 0 : 2); end
      end
      chan_enable = 4'b0100;
      for (int i = 0; i < 15; i++) begin
         tick();
         n_chk++; if (active_sel !== 2'd2 || switch_strobe !== 1'b0) begin
            n_fail++; $display("FAIL mask_single got %0d/%b want 2/0", active_sel, switch_strobe); end
      end
   endtask

   task automatic test_mode_change();
      mode = 0; sel_manual = 3; chan_enable = 4'hF; tick();
      mode = 1; tick(); tick(); tick();
      mode = 0; sel_manual = 1; tick();
      n_chk++; if (active_sel !== 2'd1 || switch_strobe !== 1'b1 || group_out !== 16'hBBBB) begin
         n_fail++; $display("FAIL mode_back got %0d/%b/%h want 1/1/bbbb", active_sel, switch_strobe, group_out); end
      group_in[1*W +: W] = 16'h1234; tick();
      n_chk++; if (group_out !== 16'h1234 || switch_strobe !== 1'b0) begin
         n_fail++; $display("FAIL data_track got %h/%b want 1234/0", group_out, switch_strobe); end
      // Counter was cleared on the switch to manual: first auto switch comes exactly D edges later.
      mode = 1;
      for (int i = 1; i <= D; i++) begin
         tick();
         n_chk++; if (switch_strobe !== (i == D)) begin
            n_fail++; $display("FAIL mode_cnt_clr edge %0d got %b want %b", i, switch_strobe, i == D); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 4) == 0) sel_manual = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) chan_enable = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) group_in[$urandom_range(0, 3)*W +: W] = 16'($urandom);
         tick();
         n_chk++; if (active_sel !== 2'(e_sel) || group_out !== e_grp || switch_strobe !== e_stb) begin
            n_fail++; $display("FAIL random[%0d] got %0d/%h/%b want %0d/%h/%b", i,
               active_sel, group_out, switch_strobe, e_sel, e_grp, e_stb); end
      end
   endtask

   initial begin
      rst_n = 0; mode = 0; sel_manual = 0; chan_enable = 4'hF;
      group_in = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      mode3 = 0; sel_manual3 = 0; chan_enable3 = 3'b111;
      group_in3 = {16'hCCCC, 16'hBBBB, 16'hAAAA};
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      test_reset();
      test_manual();
      test_out_of_range();
      test_auto_rotate();
      test_masking();
      test_mode_change();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
